floo_vc_input_buffer: RTL and testbench

FLOO_VC_INPUT_BUFFER -- requirements
Module: floo_vc_input_buffer

---
 rtl/floo_vc_input_buffer.sv | 123 ++++++++++++
 tb/tb_floo_vc_input_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/floo_vc_input_buffer.sv
// Virtual-channel input buffer for a credit-based NoC link.
// Each VC is an independent circular FIFO; every successful pop returns one
// registered credit upstream. Overflow/underflow are sticky error flags.
module floo_vc_input_buffer #(
    parameter int unsigned NumVC     = 4,
    parameter int unsigned VCDepth   = 3,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned VcIdW    = $clog2(NumVC),
    localparam int unsigned PtrW     = $clog2(VCDepth),
    localparam int unsigned CntW     = $clog2(VCDepth + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [VcIdW-1:0]           vc_id_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic [NumVC-1:0]           vc_valid_o,
    output logic [NumVC*DataWidth-1:0] vc_data_o,
    input  logic                       pop_i,
    input  logic [VcIdW-1:0]           pop_vc_i,
    output logic                       credit_valid_o,
    output logic [VcIdW-1:0]           credit_vc_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    // Advance a FIFO pointer, wrapping at VCDepth-1 (depth need not be 2^n).
    function automatic logic [PtrW-1:0] adv_ptr(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrW'(VCDepth - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    logic [DataWidth-1:0] mem_q    [NumVC][VCDepth];
    logic [PtrW-1:0]      wr_ptr_q [NumVC];
    logic [PtrW-1:0]      wr_ptr_d [NumVC];
    logic [PtrW-1:0]      rd_ptr_q [NumVC];
    logic [PtrW-1:0]      rd_ptr_d [NumVC];
    logic [CntW-1:0]      count_q  [NumVC];
    logic [CntW-1:0]      count_d  [NumVC];
    logic [NumVC-1:0]     wr_sel_s;
    logic [NumVC-1:0]     pop_sel_s;
    logic                 credit_valid_q, credit_valid_d;
    logic [VcIdW-1:0]     credit_vc_q, credit_vc_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    // Decode accepted write/pop per VC and compute next control state.
    // Full/empty are judged on the pre-cycle count, so a write to a full VC
    // is rejected even when that VC is popped in the same cycle. Ids with no
    // matching VC select nothing and therefore raise the error flags.
    always_comb begin
        for (int v = 0; v < NumVC; v++) begin
            wr_sel_s[v]  = valid_i && (vc_id_i == VcIdW'(v)) &&
                           (count_q[v] != CntW'(VCDepth));
            pop_sel_s[v] = pop_i && (pop_vc_i == VcIdW'(v)) &&
                           (count_q[v] != CntW'(0));
            wr_ptr_d[v]  = wr_sel_s[v]  ? adv_ptr(wr_ptr_q[v]) : wr_ptr_q[v];
            rd_ptr_d[v]  = pop_sel_s[v] ? adv_ptr(rd_ptr_q[v]) : rd_ptr_q[v];
            case ({wr_sel_s[v], pop_sel_s[v]})
                2'b10:   count_d[v] = count_q[v] + CntW'(1);
                2'b01:   count_d[v] = count_q[v] - CntW'(1);
                default: count_d[v] = count_q[v];
            endcase
        end
        overflow_d     = overflow_q  | (valid_i & ~(|wr_sel_s));
        underflow_d    = underflow_q | (pop_i   & ~(|pop_sel_s));
        credit_valid_d = |pop_sel_s;
        credit_vc_d    = (|pop_sel_s) ? pop_vc_i : credit_vc_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NumVC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            for (int v = 0; v < NumVC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
            end
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Payload storage: written at the write pointer, not reset.
    always_ff @(posedge clk_i) begin
        for (int v = 0; v < NumVC; v++) begin
            if (wr_sel_s[v] && !rst_i) begin
                mem_q[v][wr_ptr_q[v]] <= data_i;
            end
        end
    end

    // Head flit and occupancy per VC, taken from registered state only.
    always_comb begin
        for (int v = 0; v < NumVC; v++) begin
            vc_valid_o[v]                        = (count_q[v] != CntW'(0));
            vc_data_o[v*DataWidth +: DataWidth]  = mem_q[v][rd_ptr_q[v]];
        end
    end

    assign credit_valid_o = credit_valid_q;
    assign credit_vc_o    = credit_vc_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Scoreboard bench for floo_vc_input_buffer (NumVC=4, VCDepth=3, 64-bit).
// Per-VC reference queues hold accepted flits; a credit queue holds credits
// expected on the next cycle. Outputs are compared 1 time unit after each edge.
module tb_floo_vc_input_buffer;

    localparam int NV = 4;
    localparam int DP = 3;
    localparam int DW = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic [1:0]    vc_id_i;
    logic [DW-1:0] data_i;
    logic [NV-1:0] vc_valid_o;
    logic [NV*DW-1:0] vc_data_o;
    logic          pop_i;
    logic [1:0]    pop_vc_i;
    logic          credit_valid_o;
    logic [1:0]    credit_vc_o;
    logic          overflow_o;
    logic          underflow_o;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    logic [DW-1:0] mdl_q [NV][$];
    logic [1:0]    cred_q [$];
    logic          exp_ovf;
    logic          exp_unf;

    floo_vc_input_buffer #(.NumVC(NV), .VCDepth(DP), .DataWidth(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .vc_id_i        (vc_id_i),
        .data_i         (data_i),
        .vc_valid_o     (vc_valid_o),
        .vc_data_o      (vc_data_o),
        .pop_i          (pop_i),
        .pop_vc_i       (pop_vc_i),
        .credit_valid_o (credit_valid_o),
        .credit_vc_o    (credit_vc_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the scoreboard state for this cycle.
    task automatic check_outputs(input string ph);
        logic [1:0] c;
        for (int v = 0; v < NV; v++) begin
            check_eq($sformatf("%s_valid_vc%0d", ph, v), DW'(vc_valid_o[v]),
                     DW'(mdl_q[v].size() != 0));
            if (mdl_q[v].size() != 0)
                check_eq($sformatf("%s_head_vc%0d", ph, v), vc_data_o[v*DW +: DW], mdl_q[v][0]);
        end
        if (cred_q.size() != 0) begin
            c = cred_q.pop_front();
            check_eq({ph, "_credit_valid"}, DW'(credit_valid_o), DW'(1));
            check_eq({ph, "_credit_vc"}, DW'(credit_vc_o), DW'(c));
        end else begin
            check_eq({ph, "_no_credit"}, DW'(credit_valid_o), DW'(0));
        end
        check_eq({ph, "_overflow"}, DW'(overflow_o), DW'(exp_ovf));
        check_eq({ph, "_underflow"}, DW'(underflow_o), DW'(exp_unf));
    endtask

    // One normal cycle: predict, drive, clock, compare.
    task automatic step(input string ph, input logic wv, input logic [1:0] wvc,
                        input logic [DW-1:0] wd, input logic pv, input logic [1:0] pvc);
        logic wr_ok, pop_ok;
        wr_ok  = wv && (mdl_q[wvc].size() < DP);
        pop_ok = pv && (mdl_q[pvc].size() > 0);
        if (pop_ok) begin
            void'(mdl_q[pvc].pop_front());
            cred_q.push_back(pvc);
        end
        if (wr_ok) mdl_q[wvc].push_back(wd);
        if (wv && !wr_ok) exp_ovf = 1'b1;
        if (pv && !pop_ok) exp_unf = 1'b1;
        rst_i = 1'b0; valid_i = wv; vc_id_i = wvc; data_i = wd; pop_i = pv; pop_vc_i = pvc;
        @(posedge clk_i); #1;
        check_outputs(ph);
    endtask

    // Reset cycle; the supplied write/pop must be ignored.
    task automatic do_reset(input string ph, input logic pv, input logic [1:0] pvc);
        for (int v = 0; v < NV; v++) mdl_q[v].delete();
        cred_q.delete();
        exp_ovf = 1'b0; exp_unf = 1'b0;
        rst_i = 1'b1; valid_i = 1'b1; vc_id_i = pvc; data_i = 64'hDEAD; pop_i = pv; pop_vc_i = pvc;
        @(posedge clk_i); #1;
        check_outputs(ph);
        check_eq({ph, "_credit_vc0"}, DW'(credit_vc_o), DW'(0));
        rst_i = 1'b0; valid_i = 1'b0; pop_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; vc_id_i = 2'd0; data_i = '0; pop_i = 1'b0; pop_vc_i = 2'd0;
        exp_ovf = 1'b0; exp_unf = 1'b0;
        @(posedge clk_i); #1;
        do_reset("rst0", 1'b0, 2'd0);

        // Fill VC2, then overflow it and drain in order.
        step("fill2a", 1'b1, 2'd2, 64'hA1, 1'b0, 2'd0);
        step("fill2b", 1'b1, 2'd2, 64'hA2, 1'b0, 2'd0);
        step("fill2c", 1'b1, 2'd2, 64'hA3, 1'b0, 2'd0);
        check_eq("vc2_only", DW'(vc_valid_o), DW'(4'b0100));
        step("ovf2", 1'b1, 2'd2, 64'hA4, 1'b0, 2'd0);
        step("idle", 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step("drain2", 1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
        step("idle2", 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);

        // Full VC1: same-cycle pop and write, write rejected.
        do_reset("rst1", 1'b0, 2'd0);
        step("fill1a", 1'b1, 2'd1, 64'hB1, 1'b0, 2'd0);
        step("fill1b", 1'b1, 2'd1, 64'hB2, 1'b0, 2'd0);
        step("fill1c", 1'b1, 2'd1, 64'hB3, 1'b0, 2'd0);
        step("fullpw", 1'b1, 2'd1, 64'hB4, 1'b1, 2'd1);
        step("after1", 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);

        // VC0 with one flit: same-cycle pop and write keeps count 1.
        step("c1", 1'b1, 2'd0, 64'hC1, 1'b0, 2'd0);
        step("c1c2", 1'b1, 2'd0, 64'hC2, 1'b1, 2'd0);
        step("c2pop", 1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
        step("c2pop2", 1'b0, 2'd0, 64'h0, 1'b1, 2'd1);

        // Underflow on VC3, then streaming with wrap-around.
        do_reset("rst3", 1'b0, 2'd0);
        step("unf3", 1'b0, 2'd0, 64'h0, 1'b1, 2'd3);
        for (int i = 0; i < 10; i++)
            step("wrap3", 1'b1, 2'd3, 64'hD0 + DW'(i), (i != 0), 2'd3);
        step("wrap3e", 1'b0, 2'd0, 64'h0, 1'b1, 2'd3);
        step("wrap3i", 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);

        // Random traffic across all VCs.
        do_reset("rst4", 1'b0, 2'd0);
        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));

        // Pop then reset: credit seen once, then cleared by reset.
        do_reset("rst5", 1'b0, 2'd0);
        step("p0w", 1'b1, 2'd0, 64'hE1, 1'b0, 2'd0);
        step("p0w2", 1'b1, 2'd0, 64'hE2, 1'b0, 2'd0);
        step("p0pop", 1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
        do_reset("rstmid", 1'b0, 2'd0);
        // Pop issued in the reset cycle must not produce a credit.
        step("p1w", 1'b1, 2'd1, 64'hF1, 1'b0, 2'd0);
        step("p1ovf", 1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
        do_reset("rstpop", 1'b1, 2'd1);
        step("post", 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
